// File: rtl/data_memory_byte_if.sv
// Memory-control bus between the datapath (master) and the data memory (slave).
// Carries the execute-stage PC for the store log alongside the access fields.
interface data_memory_byte_if;
  logic [31:0] pc;
  logic [31:0] addr;
  logic [31:0] wData;
  logic        memWrite;
  logic        isByte;
  logic [31:0] rData;

  modport master (
    output pc,
    output addr,
    output wData,
    output memWrite,
    output isByte,
    input  rData
  );

  modport slave (
    input  pc,
    input  addr,
    input  wData,
    input  memWrite,
    input  isByte,
    output rData
  );
endinterface

// File: rtl/data_memory_byte.sv
// Word/byte data memory for the single-cycle datapath: combinational little-endian
// reads with lb sign extension, synchronous sw/sb writes, logged on every commit.
module data_memory_byte #(
  parameter int unsigned DEPTH  = 3072,
  parameter int unsigned ADDR_W = 12
) (
  input  logic               clk,
  input  logic               reset,
  data_memory_byte_if.slave  bus
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  logic [WORD_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] idx_c;
  logic [1:0]        lane_c;
  logic              in_range_c;
  logic [WORD_W-1:0] old_word_c;
  logic [BYTE_W-1:0] sel_byte_c;
  logic [WORD_W-1:0] merged_c;
  logic [WORD_W-1:0] wr_word_d;
  logic              wr_en_d;

  // Address decode and range check; out-of-range reads return zero.
  always_comb begin
    idx_c      = bus.addr[ADDR_W+1:2];
    lane_c     = bus.addr[1:0];
    in_range_c = (bus.addr[31:ADDR_W+2] == '0) && (32'(idx_c) < DEPTH);
    old_word_c = in_range_c ? mem_q[idx_c] : '0;
  end

  // Lane select for lb, and lane replacement for sb against the pre-edge word.
  always_comb begin
    sel_byte_c = old_word_c[7:0];
    merged_c   = old_word_c;
    case (lane_c)
      2'd0: begin
        sel_byte_c     = old_word_c[7:0];
        merged_c[7:0]  = bus.wData[7:0];
      end
      2'd1: begin
        sel_byte_c     = old_word_c[15:8];
        merged_c[15:8] = bus.wData[7:0];
      end
      2'd2: begin
        sel_byte_c      = old_word_c[23:16];
        merged_c[23:16] = bus.wData[7:0];
      end
      default: begin
        sel_byte_c      = old_word_c[31:24];
        merged_c[31:24] = bus.wData[7:0];
      end
    endcase
  end

  // Read result and write request; reset suppresses any store in the same cycle.
  always_comb begin
    bus.rData = bus.isByte ? {{(WORD_W-BYTE_W){sel_byte_c[BYTE_W-1]}}, sel_byte_c}
                           : old_word_c;
    wr_word_d = bus.isByte ? merged_c : bus.wData;
    wr_en_d   = bus.memWrite && in_range_c && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[ADDR_W'(i)] <= '0;
      end
    end else if (wr_en_d) begin
      mem_q[idx_c] <= wr_word_d;
      $display("%d@%h: *%h <= %h", $time, bus.pc, {bus.addr[31:2], 2'b00}, wr_word_d);
    end
  end

endmodule

// File: tb/tb_data_memory_byte.sv
// Directed plus randomized bench for data_memory_byte, checked against a
// byte-arithmetic reference model of the memory contents.
module tb_data_memory_byte;

  localparam int unsigned DEPTH = 3072;
  localparam int unsigned LIMIT = DEPTH * 4;

  logic clk;
  logic reset;
  data_memory_byte_if bus ();

  data_memory_byte #(.DEPTH(DEPTH), .ADDR_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned model [DEPTH];
  int passed;
  int total;
  int failed;

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic isb);
    int unsigned w;
    int unsigned b;
    if (a >= LIMIT) return 32'h0;
    w = model[a / 4];
    if (!isb) return w;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    if (b >= 128) b = b + 32'hFFFFFF00;
    return b;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic isb, input logic [31:0] d);
    int unsigned sh;
    if (a >= LIMIT) return;
    if (!isb) begin
      model[a / 4] = d;
    end else begin
      sh = 8 * (a % 4);
      model[a / 4] = (model[a / 4] & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle of stimulus: check the pre-edge read, take the edge, check the post-edge read.
  task automatic step(input string tag, input logic rst, input logic we, input logic isb,
                      input logic [31:0] a, input logic [31:0] d);
    reset        = rst;
    bus.memWrite = we;
    bus.isByte   = isb;
    bus.addr     = a;
    bus.wData    = d;
    bus.pc       = $urandom;
    #1;
    if (!rst) check({tag, "_pre"}, bus.rData, model_read(a, isb));
    @(posedge clk);
    if (rst) begin
      foreach (model[i]) model[i] = 0;
    end else if (we) begin
      model_write(a, isb, d);
    end
    #1;
    reset        = 1'b0;
    bus.memWrite = 1'b0;
    #1;
    check({tag, "_post"}, bus.rData, model_read(a, isb));
  endtask

  task automatic rd(input string tag, input logic isb, input logic [31:0] a, input logic [31:0] exp);
    bus.memWrite = 1'b0;
    bus.isByte   = isb;
    bus.addr     = a;
    #1;
    check({tag, "_model"}, bus.rData, model_read(a, isb));
    check(tag, bus.rData, exp);
  endtask

  logic [31:0] ra;
  logic [31:0] rd_data;
  int          sel;

  initial begin
    passed = 0; total = 0; failed = 0;
    reset = 1'b0; bus.memWrite = 1'b0; bus.isByte = 1'b0;
    bus.addr = '0; bus.wData = '0; bus.pc = '0;
    foreach (model[i]) model[i] = 0;
    @(negedge clk);

    // Reset then word store/load.
    step("reset0", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    rd("reset_rd0", 1'b0, 32'h0, 32'h0);
    rd("reset_rd_hi", 1'b0, 32'h2FFC, 32'h0);
    step("sw4", 1'b0, 1'b1, 1'b0, 32'h4, 32'h12345678);
    rd("lw4", 1'b0, 32'h4, 32'h12345678);
    rd("lw0", 1'b0, 32'h0, 32'h0);
    rd("lw6_unaligned", 1'b0, 32'h6, 32'h12345678);

    // Byte merge.
    step("pre_w0", 1'b0, 1'b1, 1'b0, 32'h0, 32'hAABBCCDD);
    step("sb2", 1'b0, 1'b1, 1'b1, 32'h2, 32'h00000011);
    rd("merge1", 1'b0, 32'h0, 32'hAA11CCDD);
    step("sb3", 1'b0, 1'b1, 1'b1, 32'h3, 32'hFFFFFF7E);
    rd("merge2", 1'b0, 32'h0, 32'h7E11CCDD);

    // lb sign extension.
    step("pre_w1", 1'b0, 1'b1, 1'b0, 32'h4, 32'h80FF017F);
    rd("lb4", 1'b1, 32'h4, 32'h0000007F);
    rd("lb5", 1'b1, 32'h5, 32'h00000001);
    rd("lb6", 1'b1, 32'h6, 32'hFFFFFFFF);
    rd("lb7", 1'b1, 32'h7, 32'hFFFFFF80);

    // Read-during-write returns old data, then new.
    step("pre_w2", 1'b0, 1'b1, 1'b0, 32'h8, 32'h1);
    step("rdw", 1'b0, 1'b1, 1'b0, 32'h8, 32'h2);
    rd("rdw_new", 1'b0, 32'h8, 32'h2);

    // Back-to-back sb into one word.
    step("bb0", 1'b0, 1'b1, 1'b1, 32'hC, 32'h01);
    step("bb1", 1'b0, 1'b1, 1'b1, 32'hD, 32'h02);
    step("bb2", 1'b0, 1'b1, 1'b1, 32'hE, 32'h03);
    step("bb3", 1'b0, 1'b1, 1'b1, 32'hF, 32'h84);
    rd("bb_word", 1'b0, 32'hC, 32'h84030201);

    // Out of range.
    step("oor_sw", 1'b0, 1'b1, 1'b0, 32'h3000, 32'hCAFEF00D);
    rd("oor_lw", 1'b0, 32'h3000, 32'h0);
    rd("oor_wrap", 1'b0, 32'h0, 32'h7E11CCDD);
    step("oor_hi", 1'b0, 1'b1, 1'b0, 32'h00010004, 32'h55555555);
    rd("oor_hi_alias", 1'b0, 32'h4, 32'h80FF017F);
    rd("oor_hi_rd", 1'b0, 32'h00010004, 32'h0);

    // Reset priority mid-operation.
    step("rst_we", 1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    rd("rst_w4", 1'b0, 32'h10, 32'h0);
    rd("rst_w0", 1'b0, 32'h0, 32'h0);
    rd("rst_w1", 1'b0, 32'h4, 32'h0);
    rd("rst_w3", 1'b0, 32'hC, 32'h0);

    // Randomized mix against the model.
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 19));
      if (sel == 0)      ra = 32'h3000 + 32'($urandom_range(0, 63));
      else if (sel == 1) ra = $urandom;
      else if (sel <= 3) ra = 32'h2FC0 + 32'($urandom_range(0, 63));
      else               ra = 32'($urandom_range(0, 127));
      rd_data = $urandom;
      step("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
           $urandom_range(0, 1) == 1, ra, rd_data);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_memory_byte.md
Name: data_memory_byte

Overview:
- Data memory responder driven by the decoder's memory-control outputs (memWrite, isByte) and the ALU result address.
- Serves lw/sw (word) and lb/sb (byte) accesses in the single-cycle P4 datapath.
- Writes are synchronous; reads are combinational.
- Every committed write is logged through $display for the grading trace.

Parameters:
- DEPTH, 3072, number of 32-bit words (12 KiB).
- ADDR_W, 12, word-index width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- pc  input  32  PC of the instruction in execute; used only in the write log.
- addr  input  32  byte address from the ALU.
- wData  input  32  store data (rt value); sb uses bits [7:0].
- memWrite  input  1  store enable (sw or sb).
- isByte  input  1  1 = byte access (lb/sb), 0 = word access (lw/sw).
- rData  output  32  load result, already aligned and extended for the register file.

Behaviour:
- Storage: DEPTH x 32 array. Word index = addr[ADDR_W+1:2]. Byte lane = addr[1:0], little-endian (lane 0 = bits [7:0], lane 3 = bits [31:24]).
- Reset:
  - On a rising edge with reset=1, every word is cleared to 0 and no write is performed, even if memWrite=1.
  - No log line is printed during reset.
  - rData reads 0 in the cycle after reset.
- Read (combinational, zero latency):
  - Word mode (isByte=0): rData = mem[index]. addr[1:0] is ignored; no alignment trap.
  - Byte mode (isByte=1): rData = the selected lane, sign-extended to 32 bits from bit 7 of that byte.
  - rData is a function of addr and isByte only. memWrite does not affect it.
  - Same-cycle read of a word being written returns the OLD contents. The new value is visible after the edge.
- Write (rising edge, reset=0, memWrite=1):
  - Word mode: mem[index] <= wData.
  - Byte mode: mem[index] <= old word with only lane addr[1:0] replaced by wData[7:0]. The other three bytes are preserved exactly.
- Write log, on every committed write, exactly one line:
  - $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2],2'b00}, newWord).
  - newWord is the full merged 32-bit word, including for sb.
- Out-of-range address (index >= DEPTH, or addr[31:ADDR_W+2] != 0):
  - Write is dropped and no log line is printed.
  - Read returns 0.
- Simultaneous events:
  - reset and memWrite in the same cycle: reset wins.
  - Back-to-back sb to the same word on consecutive cycles: each merge uses the result of the previous edge, so no byte is lost.
- memWrite=0: array unchanged, no log line.
- No X propagation: with all inputs known, rData is always known.

Test Plan:
- Reset then word store/load: reset one cycle; sw addr=0x00000004, wData=0x12345678 -> log "@pc: *00000004 <= 12345678"; next cycle lw addr=4 gives rData=0x12345678, and addr=0 gives 0.
- Byte merge:
  - Preload word 0 = 0xAABBCCDD.
  - sb addr=0x2, wData=0x00000011 -> mem[0]=0xAA11CCDD, log shows 0xAA11CCDD.
  - sb addr=0x3, wData=0xFFFFFF7E -> mem[0]=0x7E11CCDD.
- lb sign extension: mem[1]=0x80FF017F.
  - lb addr=4 -> 0x0000007F.
  - addr=5 -> 0x00000001.
  - addr=6 -> 0xFFFFFFFF.
  - addr=7 -> 0xFFFFFF80.
- Read-during-write: mem[2]=0x1; same cycle sw addr=8, wData=0x2 -> rData=0x1 before the edge and 0x2 after.
- Reset priority mid-operation: reset=1 with memWrite=1, addr=0x10, wData=0xDEADBEEF -> no log line, mem[4]=0, and all previously written words read 0.
- Out of range: sw addr=0x00003000 (index 3072) -> no log line, no array change; lw addr=0x00003000 -> rData=0.
